// File: rtl/instr_loader_if.sv
// Byte-stream and instruction-memory write bundle for the program loader.
// The master side feeds the stream and observes writes; the slave side is the loader.
interface instr_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              instr_WE;
    logic [31:0]       instr_WD;
    logic [ADDR_W-1:0] word_addr;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, instr_WE, instr_WD, word_addr
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, instr_WE, instr_WD, word_addr
    );
endinterface

// File: rtl/instr_loader.sv
// Length-prefixed byte-stream loader for the MIPS instruction memory; holds the CPU in reset until loaded.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    instr_loader_if.slave bus,
    output logic          cpu_rstn,
    output logic          done,
    output logic          err
);
    localparam int unsigned CNT_W  = 17;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        RECV,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               ready_q, ready_d;
    logic               we_q, we_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               rstn_q, rstn_d;
    logic               fire;
    logic [LEN_W-1:0]   len_full;
    logic [CNT_W-1:0]   cnt_inc;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    assign fire     = bus.byte_valid && ready_q;
    assign len_full = {bus.byte_in, len_q[7:0]};
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        word_d  = word_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) state_d = LEN0;
            end
            LEN0: begin
`ifdef LOADER_CHECKSUM_EN
                csum_d = 8'd0;
`endif
                if (fire) begin
                    len_d[7:0] = bus.byte_in;
                    state_d    = LEN1;
                end
            end
            LEN1: begin
                if (fire) begin
                    len_d = len_full;
                    if ((len_full == LEN_W'(0)) || (CNT_W'(len_full) > CNT_W'(MEM_DEPTH))) begin
                        state_d = ERROR;
                    end else begin
                        state_d = RECV;
                        idx_d   = 2'd0;
                        cnt_d   = CNT_W'(0);
                    end
                end
            end
            RECV: begin
                if (fire) begin
                    word_d[{idx_q, 3'b000} +: 8] = bus.byte_in;
                    idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ bus.byte_in;
`endif
                    if (idx_q == 2'd3) state_d = WRITE;
                end
            end
            WRITE: begin
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_W'(len_q)) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = RECV;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (fire) state_d = (bus.byte_in == csum_q) ? DONE : ERROR;
            end
`endif
            DONE: begin
                if (start) state_d = LEN0;
            end
            ERROR: begin
                if (start) state_d = LEN0;
            end
            default: state_d = IDLE;
        endcase

        // Outputs follow the state being entered so they are flops, not decode of inputs
        ready_d = (state_d == LEN0) || (state_d == LEN1) || (state_d == RECV)
`ifdef LOADER_CHECKSUM_EN
                  || (state_d == CSUM)
`endif
                  ;
        we_d    = (state_d == WRITE);
        done_d  = (state_d == DONE);
        err_d   = (state_d == ERROR);
        rstn_d  = (state_d == DONE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= CNT_W'(0);
            len_q   <= LEN_W'(0);
            word_q  <= WORD_W'(0);
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rstn_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            word_q  <= word_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rstn_q  <= rstn_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.instr_WE   = we_q;
    assign bus.instr_WD   = word_q;
    assign bus.word_addr  = cnt_q[ADDR_W-1:0];
    assign cpu_rstn       = rstn_q;
    assign done           = done_q;
    assign err            = err_q;
endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: streams are decoded by a queue-based reference model
// and the observed write pulses and final status are compared against it.
module tb_instr_loader;
    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned ADDR_W    = 8;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic cpu_rstn;
    logic done;
    logic err;

    instr_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .cpu_rstn (cpu_rstn),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [7:0]  stream[$];
    logic [31:0] words[$];
    logic [39:0] got_q[$];
    logic [39:0] exp_q[$];
    bit          exp_ok;
    bit          exp_len_ok;

    // Record every write pulse as {addr, word}
    always @(negedge clk) begin
        if (bus.instr_WE) got_q.push_back({bus.word_addr, bus.instr_WD});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic make_stream(input int unsigned n, input bit bad_csum);
        logic [7:0] x;
        logic [7:0] bt;
        x = 8'd0;
        stream.delete();
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        foreach (words[k]) begin
            for (int b = 0; b < 4; b++) begin
                bt = 8'(words[k] >> (8 * b));
                stream.push_back(bt);
                x = x ^ bt;
            end
        end
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(x ^ {7'd0, bad_csum});
`else
        if (bad_csum) x = 8'd0;
`endif
    endtask

    // Decode the stream from the format rules alone
    task automatic model();
        int unsigned n;
        logic [7:0]  x;
        logic [31:0] w;
        n = {stream[1], stream[0]};
        exp_q.delete();
        exp_len_ok = (n != 0) && (n <= MEM_DEPTH);
        exp_ok     = exp_len_ok;
        if (exp_len_ok) begin
            x = 8'd0;
            for (int k = 0; k < int'(n); k++) begin
                w = 32'd0;
                for (int b = 0; b < 4; b++) begin
                    w = w | (32'(stream[2 + 4*k + b]) << (8 * b));
                    x = x ^ stream[2 + 4*k + b];
                end
                exp_q.push_back({8'(k), w});
            end
            if (CSUM_EN) exp_ok = (x == stream[2 + 4*int'(n)]);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: valid always high, 1: valid every other cycle, 2: random valid plus stray start pulses
    task automatic send_bytes(input int mode);
        int i   = 0;
        int cyc = 0;
        bit v;
        while (i < stream.size() && cyc < 20000) begin
            @(negedge clk);
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 1) == 1);
            endcase
            if (mode == 2) start = ($urandom_range(0, 7) == 0);
            bus.byte_valid = v;
            bus.byte_in    = v ? stream[i] : 8'($urandom);
            if (v && bus.byte_ready) i++;
            cyc++;
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        start          = 1'b0;
        check("stream_sent", 64'(i), 64'(stream.size()));
    endtask

    task automatic run_load(input int mode);
        int w;
        got_q.delete();
        model();
        pulse_start();
        check("start_ready", 64'(bus.byte_ready), 64'd1);
        send_bytes(mode);
        w = 0;
        while (!(done || err) && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("latency", 64'(w), (CSUM_EN || !exp_len_ok) ? 64'd0 : 64'd1);
        @(negedge clk);
        check("done", 64'(done), 64'(exp_ok));
        check("err", 64'(err), 64'(!exp_ok));
        check("cpu_rstn", 64'(cpu_rstn), 64'(exp_ok));
        check("ready_after", 64'(bus.byte_ready), 64'd0);
        check("n_writes", 64'(got_q.size()), 64'(exp_q.size()));
        foreach (exp_q[k]) begin
            if (k < got_q.size()) check("write", 64'(got_q[k]), 64'(exp_q[k]));
        end
    endtask

    task automatic rand_words(input int unsigned n);
        words.delete();
        for (int k = 0; k < int'(n); k++) words.push_back($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        rst            = 1'b1;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'd0;
        #3;
        check("reset_vals", {19'd0, bus.byte_ready, bus.instr_WE, bus.instr_WD, bus.word_addr,
                             cpu_rstn, done, err}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a word: no write, back to idle
        words = '{32'hAABBCCDD};
        make_stream(1, 1'b0);
        while (stream.size() > 4) void'(stream.pop_back());
        got_q.delete();
        pulse_start();
        send_bytes(0);
        rst = 1'b1;
        #1;
        check("midrecv_reset_vals", {19'd0, bus.byte_ready, bus.instr_WE, bus.instr_WD, bus.word_addr,
                                     cpu_rstn, done, err}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrecv_idle", 64'(bus.byte_ready), 64'd0);
        check("midrecv_no_we", 64'(got_q.size()), 64'd0);

        // Single word load
        words = '{32'h12345678};
        make_stream(1, 1'b0);
        run_load(0);

        // Three words with valid toggling
        words = '{32'h20080005, 32'h20090007, 32'h01095020};
        make_stream(3, 1'b0);
        run_load(1);

        // Bad lengths
        stream = '{8'h00, 8'h00};
        run_load(0);
        stream = '{8'h01, 8'h01};
        run_load(0);

`ifdef LOADER_CHECKSUM_EN
        words = '{32'h12345678};
        make_stream(1, 1'b1);
        run_load(0);
        make_stream(1, 1'b0);
        run_load(0);
`endif

        // Random short programs
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 8);
            rand_words(n);
            make_stream(n, ($urandom_range(0, 3) == 0));
            run_load($urandom_range(0, 2));
        end

        // Full-depth load, then a restart must drop cpu_rstn immediately
        rand_words(MEM_DEPTH);
        make_stream(MEM_DEPTH, 1'b0);
        run_load(2);
        if (got_q.size() > 0) check("last_addr", 64'(got_q[got_q.size()-1][39:32]), 64'd255);
        pulse_start();
        check("restart_rstn", 64'(cpu_rstn), 64'd0);
        check("restart_done", 64'(done), 64'd0);
        check("restart_ready", 64'(bus.byte_ready), 64'd1);

        // Finish the restarted load; the extra start in LEN0 is ignored
        rand_words(2);
        make_stream(2, 1'b0);
        run_load(1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
